adder_rr_arbiter: RTL

Round-robin arbiter that shares a single N-bit adder among REQ requesters. Each requester presents two operands and a carry-in; the arbiter grants one requester per cycle and computes `{cout, sum} = a + b + cin`. It returns the registered result, tagged with the requester index, through a valid/ready output port. It sits between the lab's multiple operand sources (counters, accumulators, test stimulus) and one shared adder instance, replacing per-source adders.

---
 rtl/adder_rr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_rr_arbiter
//  Function : Round-robin arbiter sharing one N-bit adder among REQ requesters;
//             registered result tagged with requester index, valid/ready out.
//             Optional macro ADDER_ARB_OVF_EN adds a signed-overflow output.
//  Revision : 1.0  initial release
// ============================================================================
module adder_rr_arbiter #(
    parameter  int N   = 16,
    parameter  int REQ = 4,
    localparam int IDW = $clog2(REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ-1:0]       req,
    input  logic [REQ*N-1:0]     a_flat,
    input  logic [REQ*N-1:0]     b_flat,
    input  logic [REQ-1:0]       cin,
    output logic [REQ-1:0]       ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_sum,
    output logic                 res_cout,
    output logic [IDW-1:0]       res_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                 res_ovf
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   sum_q;
    logic           cout_q;
    logic [IDW-1:0] id_q;

    logic           w_accept;
    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [N-1:0]   w_a_sel;
    logic [N-1:0]   w_b_sel;
    logic           w_cin_sel;
    logic [N:0]     w_sum;

    assign res_valid = (state_q == ST_FULL);
    assign w_accept  = (|req) && (!res_valid || res_ready) && !rst;

    // Scan from ptr upward, wrapping, and take the first active request.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < REQ; k++) begin
            if (!w_found && req[(int'(ptr_q) + k) % REQ]) begin
                w_found  = 1'b1;
                w_winner = IDW'((int'(ptr_q) + k) % REQ);
            end
        end
    end

    always_comb begin
        ack = '0;
        if (w_accept) begin
            ack[w_winner] = 1'b1;
        end
    end

    assign w_a_sel   = a_flat[int'(w_winner)*N +: N];
    assign w_b_sel   = b_flat[int'(w_winner)*N +: N];
    assign w_cin_sel = cin[w_winner];
    assign w_sum     = {1'b0, w_a_sel} + {1'b0, w_b_sel} + {{N{1'b0}}, w_cin_sel};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: if (w_accept) state_d = ST_FULL;
            ST_FULL: begin
                if (w_accept)       state_d = ST_FULL;
                else if (res_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (w_accept) begin
            ptr_d = (w_winner == IDW'(REQ-1)) ? '0 : w_winner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (w_accept) begin
                sum_q  <= w_sum[N-1:0];
                cout_q <= w_sum[N];
                id_q   <= w_winner;
            end
        end
    end

    assign res_sum  = sum_q;
    assign res_cout = cout_q;
    assign res_id   = id_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;

    // Two's-complement overflow: like-signed operands producing a different sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (w_accept) begin
            ovf_q <= (w_a_sel[N-1] == w_b_sel[N-1]) && (w_sum[N-1] != w_a_sel[N-1]);
        end
    end

    assign res_ovf = ovf_q;
`endif

endmodule
`default_nettype wire
